mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port 64K linear memory between two requesters: the 6502C CPU core and the ANTIC-style display DMA engine.
- Sequences every access into fixed phases, drives the memory's enable, we_L, re_L, address and data controls, and returns read data with a one-cycle ack pulse.
- Holds the CPU through cpu_rdy while DMA owns or is claiming the memory (cycle stealing).
- Sits between the CPU/DMA blocks and the memory instance at the top level.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- MAX_DMA_RUN, 4, consecutive DMA grants allowed before a waiting CPU is forced in. Used only with the optional feature. Legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we_L  in  1  0 = write, 1 = read; sampled at grant.
- cpu_addr  in  ADDR_W  CPU address; sampled at grant.
- cpu_wdata  in  DATA_W  CPU write data; sampled at grant.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdy  out  1  0 = CPU must stall (6502 RDY).
- dma_req  in  1  DMA request; held until dma_ack.
- dma_we_L  in  1  0 = write, 1 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  read data; valid while dma_ack = 1.
- dma_ack  out  1  one-cycle completion pulse.
- mem_enable  out  1  memory enable.
- mem_we_L  out  1  memory write strobe, active low.
- mem_re_L  out  1  memory read strobe, active low.
- mem_address  out  ADDR_W  memory address.
- mem_data_o  out  DATA_W  write data to the memory data bus.
- mem_data_oe  out  1  1 = top level drives mem_data_o onto the inout bus.
- mem_data_i  in  DATA_W  memory data bus readback.

Behaviour:
- Reset values (asynchronous, while reset_L = 0):
  - state = IDLE.
  - mem_enable = 0, mem_we_L = 1, mem_re_L = 1, mem_data_oe = 0.
  - mem_address = 0, mem_data_o = 0.
  - cpu_ack = 0, dma_ack = 0, cpu_rdata = 0, dma_rdata = 0.
  - cpu_rdy = 1; run counter = 0.
- Reset asserted mid-ACCESS aborts the access. No ack is issued. mem_we_L returns to 1 immediately, so no write lands.
- FSM states:
  - IDLE: if any request is pending, arbitrate and latch owner, we_L, address and wdata into registers, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - mem_enable = 1; mem_address = latched address.
    - Write: mem_we_L = 0, mem_data_oe = 1, mem_data_o = latched wdata. The memory commits the write at the closing posedge.
    - Read: mem_re_L = 0. mem_data_i is captured into the owner's rdata register at the closing posedge.
    - Always go to DONE.
  - DONE (exactly 1 cycle): owner's ack = 1, all memory strobes inactive, then go to IDLE. Requests are not arbitrated in DONE, so a requester that drops req after ack is never re-granted.
- Latency: req high before edge k -> ACCESS in cycle k..k+1 -> ack in cycle k+1..k+2. Sustained throughput is one access per 3 cycles.
- Arbitration: fixed priority, DMA over CPU. A simultaneous request in IDLE grants DMA.
- cpu_rdy is combinational: 0 when dma_req = 1 or the current owner is DMA (ACCESS or DONE); else 1.
- rdata registers hold their last value until the next read by the same owner. A write never updates rdata.
- The ack of the non-owner is always 0. cpu_ack and dma_ack are never both 1.
- Request inputs that change while not in IDLE are ignored until the next IDLE arbitration.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit run counter increments on each DMA grant made while cpu_req = 1, and clears on any CPU grant.
  - When the counter equals MAX_DMA_RUN and cpu_req = 1, the next IDLE arbitration grants the CPU even if dma_req = 1.
  - cpu_rdy is forced to 1 for that forced grant.
- Undefined: no counter is synthesized and DMA priority is absolute. A continuous dma_req starves the CPU indefinitely.

Test Plan:
- Reset then CPU read: mem[0x1234] = 0xA5; cpu_req with cpu_we_L = 1 and cpu_addr = 0x1234 -> mem_re_L = 0 for exactly one cycle, then cpu_ack for one cycle with cpu_rdata = 0xA5; dma_ack stays 0.
- DMA write then CPU readback: dma write of 0x3C to 0x8000, then cpu read of 0x8000 -> dma_ack, then cpu_ack with cpu_rdata = 0x3C. Each access spans 3 cycles and mem_data_oe = 1 only during the write ACCESS cycle.
- Simultaneous requests: cpu_req and dma_req rise on the same edge -> DMA is granted first and cpu_rdy = 0 until DMA's DONE ends. CPU ACCESS follows 3 cycles after DMA ACCESS.
- Reset mid-write: drop reset_L during a CPU ACCESS writing 0xFF to 0x0010 (previously 0x00), before the closing edge -> mem[0x0010] stays 0x00, no ack is issued, and all outputs take reset values at once.
- Starvation with MEM_ARB_STARVE_GUARD_EN, MAX_DMA_RUN = 4: dma_req held high and cpu_req high -> grant sequence is D, D, D, D, C, D, ...; without the macro, the CPU receives zero grants over 100 cycles.
- Back-to-back from one requester: CPU reissues req on the cycle after cpu_ack for 3 writes -> 3 acks, spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Memory-side bus between the mem_arbiter and the single-port 64K memory.
//
// Signals:
//   mem_enable   memory enable (high for the single access cycle)
//   mem_we_L     write strobe, active low
//   mem_re_L     read strobe, active low
//   mem_address  access address
//   mem_data_o   write data toward the memory data bus
//   mem_data_oe  1 = top level drives mem_data_o onto the inout bus
//   mem_data_i   memory data bus readback
//
// Modports:
//   master  the arbiter (drives strobes, address and write data)
//   slave   the memory side (drives readback data)
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              mem_enable;
   logic              mem_we_L;
   logic              mem_re_L;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_data_oe;
   logic [DATA_W-1:0] mem_data_i;

   modport master (
      output mem_enable,
      output mem_we_L,
      output mem_re_L,
      output mem_address,
      output mem_data_o,
      output mem_data_oe,
      input  mem_data_i
   );

   modport slave (
      input  mem_enable,
      input  mem_we_L,
      input  mem_re_L,
      input  mem_address,
      input  mem_data_o,
      input  mem_data_oe,
      output mem_data_i
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-port 64K memory between the 6502C CPU core and the
// display DMA engine. Every access runs IDLE -> ACCESS -> DONE: the winner
// is latched in IDLE, the memory is strobed for exactly one ACCESS cycle,
// and the owner sees a one-cycle ack in DONE. DMA has fixed priority and
// steals cycles from the CPU by pulling cpu_rdy low.
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//   When defined, a run counter limits consecutive DMA grants made while the
//   CPU is waiting; after MAX_DMA_RUN of them the CPU is granted next.
//   When undefined, DMA priority is absolute.
//
// Ports:
//   clock, reset_L           system clock, asynchronous active-low reset
//   cpu_req/we_L/addr/wdata  CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack       CPU read data (valid with ack), completion pulse
//   cpu_rdy                  0 = CPU must stall
//   dma_req/we_L/addr/wdata  DMA request (held until dma_ack)
//   dma_rdata, dma_ack       DMA read data (valid with ack), completion pulse
//   mem_bus                  memory-side bus (mem_arbiter_if.master)
module mem_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int MAX_DMA_RUN = 4
) (
   input  logic              clock,
   input  logic              reset_L,
   input  logic              cpu_req,
   input  logic              cpu_we_L,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_rdy,
   input  logic              dma_req,
   input  logic              dma_we_L,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   mem_arbiter_if.master     mem_bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   if (MAX_DMA_RUN < 1 || MAX_DMA_RUN > 15) begin : g_bad_run
      $error("mem_arbiter: MAX_DMA_RUN must be in 1..15");
   end

   logic [1:0]        state;
   logic              owner_dma;
   logic              lat_we_L;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              any_req;
   logic              grant_dma;
   logic              in_access;
   logic              write_access;

   assign any_req = cpu_req | dma_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0] run_count;
   logic       force_cpu;
   logic       forced_grant;

   // A waiting CPU that has sat through MAX_DMA_RUN DMA grants wins the
   // next arbitration regardless of dma_req.
   assign force_cpu = cpu_req && (run_count == 4'(MAX_DMA_RUN));
   assign grant_dma = dma_req && !force_cpu;

   // The counter only advances on DMA grants the CPU actually waited
   // through, so a lone DMA stream never pre-charges it.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         run_count    <= 4'd0;
         forced_grant <= 1'b0;
      end else if (state == IDLE && any_req) begin
         if (grant_dma) begin
            forced_grant <= 1'b0;
            if (cpu_req) begin
               run_count <= run_count + 4'd1;
            end
         end else begin
            run_count    <= 4'd0;
            forced_grant <= force_cpu;
         end
      end
   end

   // A forced CPU grant must not be stalled by the still-pending DMA request.
   always_comb begin
      cpu_rdy = !(dma_req || (state != IDLE && owner_dma));
      if (state == IDLE && force_cpu) begin
         cpu_rdy = 1'b1;
      end else if (state != IDLE && !owner_dma && forced_grant) begin
         cpu_rdy = 1'b1;
      end
   end
`else
   assign grant_dma = dma_req;

   // Stall the CPU whenever DMA is claiming or holding the memory.
   assign cpu_rdy = !(dma_req || (state != IDLE && owner_dma));
`endif

   // Sequencer: arbitration and request capture happen only in IDLE, so
   // request changes during ACCESS/DONE are invisible until the next IDLE.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state     <= IDLE;
         owner_dma <= 1'b0;
         lat_we_L  <= 1'b1;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state     <= ACCESS;
                  owner_dma <= grant_dma;
                  lat_we_L  <= grant_dma ? dma_we_L  : cpu_we_L;
                  lat_addr  <= grant_dma ? dma_addr  : cpu_addr;
                  lat_wdata <= grant_dma ? dma_wdata : cpu_wdata;
               end
            end
            ACCESS:  state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Read data is captured at the edge that closes a read ACCESS and is
   // held until the same owner reads again; writes leave it alone.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else if (state == ACCESS && lat_we_L) begin
         if (owner_dma) begin
            dma_rdata <= mem_bus.mem_data_i;
         end else begin
            cpu_rdata <= mem_bus.mem_data_i;
         end
      end
   end

   // Strobes decode straight from the state register so that reset
   // releases mem_we_L at once and aborts an in-flight write.
   assign in_access    = (state == ACCESS);
   assign write_access = in_access && !lat_we_L;

   assign mem_bus.mem_enable  = in_access;
   assign mem_bus.mem_we_L    = !write_access;
   assign mem_bus.mem_re_L    = !(in_access && lat_we_L);
   assign mem_bus.mem_data_oe = write_access;
   assign mem_bus.mem_address = in_access ? lat_addr : '0;
   assign mem_bus.mem_data_o  = write_access ? lat_wdata : '0;

   assign cpu_ack = (state == DONE) && !owner_dma;
   assign dma_ack = (state == DONE) && owner_dma;

endmodule
